// File: rtl/binary_to_bcd_converter_if.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd_converter_if
// Purpose  : Request/result bundle for the iterative binary-to-BCD converter.
// Ports    : value   - unsigned binary operand (WIDTH bits)
//            start   - conversion request, sampled on the rising clock edge
//            digit_1 - thousands digit (leftmost display position)
//            digit_2 - hundreds digit
//            digit_3 - tens digit
//            digit_4 - units digit
//            busy    - conversion in progress
//            done    - one-cycle pulse, new digits valid
//            master  - requester side (drives value/start)
//            slave   - converter side (drives digits/busy/done)
// Revision : 1.0 - initial release
// ============================================================================
interface binary_to_bcd_converter_if #(
   parameter int WIDTH = 12
);
   logic [WIDTH-1:0] value;
   logic             start;
   logic [3:0]       digit_1;
   logic [3:0]       digit_2;
   logic [3:0]       digit_3;
   logic [3:0]       digit_4;
   logic             busy;
   logic             done;

   modport master (
      output value, start,
      input  digit_1, digit_2, digit_3, digit_4, busy, done
   );

   modport slave (
      input  value, start,
      output digit_1, digit_2, digit_3, digit_4, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/binary_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd_converter
// Purpose  : Sequential double-dabble converter. A start in IDLE captures a
//            WIDTH-bit operand; WIDTH shift-add-3 iterations later the four
//            BCD digits are registered and done pulses for one cycle.
// Ports    : clock - rising-edge clock for all state
//            reset - asynchronous, active-low; clears all state
//            bus   - slave side of binary_to_bcd_converter_if
//                    (value/start in, digit_1..digit_4/busy/done out)
// Params   : WIDTH - operand width, legal range 1..13 (max 8191 -> 4 digits);
//                    must match the WIDTH of the connected interface
// Revision : 1.0 - initial release
// ============================================================================
module binary_to_bcd_converter #(
   parameter int WIDTH = 12
) (
   input  wire logic                 clock,
   input  wire logic                 reset,
   binary_to_bcd_converter_if.slave  bus
);

   // Counter only has to reach WIDTH, so it can never wrap mid-conversion.
   localparam int                CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]          r_state;
   logic [WIDTH-1:0]    r_shift;
   logic [15:0]         r_scratch;
   logic [CNT_W-1:0]    r_count;
   logic [15:0]         r_digits;
   logic                r_busy;
   logic                r_done;

   logic [15:0]         w_adj;
   logic [15+WIDTH:0]   w_cat;
   logic [15:0]         w_next_scratch;
   logic [WIDTH-1:0]    w_next_shift;

   // Add-3 correction: a nibble >= 5 would exceed 9 after doubling.
   for (genvar i = 0; i < 4; i++) begin : g_adj
      assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5)
                               ? r_scratch[4*i +: 4] + 4'd3
                               : r_scratch[4*i +: 4];
   end

   // One iteration: the corrected scratch and the operand shift left as one word.
   assign w_cat          = {w_adj, r_shift} << 1;
   assign w_next_scratch = w_cat[15+WIDTH:WIDTH];
   assign w_next_shift   = w_cat[WIDTH-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_scratch <= '0;
         r_count   <= '0;
         r_digits  <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_shift   <= bus.value;
                  r_scratch <= '0;
                  r_count   <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               r_scratch <= w_next_scratch;
               r_shift   <= w_next_shift;
               r_count   <= r_count + 1'b1;
               // Final iteration: publish the result straight from the
               // combinational next-scratch so latency is exactly WIDTH.
               if (r_count == LAST_ITER) begin
                  r_digits <= w_next_scratch;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.digit_1 = r_digits[15:12];
   assign bus.digit_2 = r_digits[11:8];
   assign bus.digit_3 = r_digits[7:4];
   assign bus.digit_4 = r_digits[3:0];
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_binary_to_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_to_bcd_converter
// Purpose  : Self-checking bench for binary_to_bcd_converter (WIDTH = 12).
//            Expected digits come from decimal arithmetic on the operand.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binary_to_bcd_converter;

   localparam int WIDTH = 12;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   logic [15:0] shown = 16'h0000;   // digits the display should currently hold

   binary_to_bcd_converter_if #(.WIDTH(WIDTH)) bus ();

   binary_to_bcd_converter #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [15:0] seen();
      return {bus.digit_1, bus.digit_2, bus.digit_3, bus.digit_4};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      bus.start = 1'b1;
      bus.value = 12'd123;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bus.busy, bus.done, seen()} !== 18'h0) begin
            failures++;
            $display("FAIL reset_hold cycle %0d: busy=%b done=%b digits=%h, need 0/0/0000",
                     c, bus.busy, bus.done, seen());
         end
      end
      reset = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_accept: busy=%b, need 1", bus.busy);
      end
      for (int n = 1; n <= 11; n++) tick();
      tick();
      checks++;
      if (bus.done !== 1'b1 || seen() !== to_bcd(123)) begin
         failures++;
         $display("FAIL reset_first_conv: done=%b digits=%h, need 1/%h",
                  bus.done, seen(), to_bcd(123));
      end
      shown = to_bcd(123);
      tick();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_latency();
      int vals[3] = '{1234, 4095, 0};
      foreach (vals[i]) begin
         bus.start = 1'b1;
         bus.value = 12'(vals[i]);
         tick();                               // edge k
         bus.start = 1'b0;
         for (int c = 0; c <= 11; c++) begin
            if (c > 0) tick();
            checks++;
            if ({bus.busy, bus.done, seen()} !== {2'b10, shown}) begin
               failures++;
               $display("FAIL latency_busy v=%0d edge k+%0d: busy=%b done=%b digits=%h, need 1/0/%h",
                        vals[i], c, bus.busy, bus.done, seen(), shown);
            end
         end
         tick();                               // edge k+12
         checks++;
         if ({bus.busy, bus.done, seen()} !== {2'b01, to_bcd(vals[i])}) begin
            failures++;
            $display("FAIL latency_done v=%0d: busy=%b done=%b digits=%h, need 0/1/%h",
                     vals[i], bus.busy, bus.done, seen(), to_bcd(vals[i]));
         end
         shown = to_bcd(vals[i]);
         tick();
         checks++;
         if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL done_width v=%0d: done=%b, need 0", vals[i], bus.done);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_ignore_start();
      int n;
      bus.start = 1'b1;
      bus.value = 12'd999;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 20) begin tick(); n++; end
      checks++;
      if (bus.done !== 1'b1 || seen() !== to_bcd(999)) begin
         failures++;
         $display("FAIL ignore_first: done=%b digits=%h, need 1/%h", bus.done, seen(), to_bcd(999));
      end
      shown = to_bcd(999);
      tick();
      bus.start = 1'b1;
      bus.value = 12'd42;
      tick();                                  // edge k
      bus.start = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         if (c == 5) begin bus.start = 1'b1; bus.value = 12'd7; end
         tick();
         bus.start = 1'b0;
         checks++;
         if ({bus.busy, bus.done, seen()} !== {2'b10, shown}) begin
            failures++;
            $display("FAIL ignore_hold edge k+%0d: busy=%b done=%b digits=%h, need 1/0/%h",
                     c, bus.busy, bus.done, seen(), shown);
         end
      end
      tick();
      checks++;
      if (bus.done !== 1'b1 || seen() !== to_bcd(42)) begin
         failures++;
         $display("FAIL ignore_result: done=%b digits=%h, need 1/%h", bus.done, seen(), to_bcd(42));
      end
      shown = to_bcd(42);
      for (int c = 0; c < 14; c++) begin
         tick();
         checks++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_queue cycle %0d: busy=%b done=%b, need 0/0", c, bus.busy, bus.done);
         end
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_back_to_back();
      int n;
      logic [15:0] want;
      bus.start = 1'b1;
      bus.value = 12'd100;
      tick();                                  // edge k accepts 100
      bus.value = 12'd250;
      for (int c = 1; c <= 26; c++) begin
         tick();
         want = (c < 12) ? shown : (c < 25) ? to_bcd(100) : to_bcd(250);
         checks++;
         if ({bus.busy, bus.done, seen()} !==
             {(c != 12 && c != 25), (c == 12 || c == 25), want}) begin
            failures++;
            $display("FAIL back_to_back edge k+%0d: busy=%b done=%b digits=%h, need %b/%b/%h",
                     c, bus.busy, bus.done, seen(), (c != 12 && c != 25), (c == 12 || c == 25), want);
         end
      end
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 20) begin tick(); n++; end
      checks++;
      if (bus.done !== 1'b1 || seen() !== to_bcd(250)) begin
         failures++;
         $display("FAIL back_to_back_third: done=%b digits=%h, need 1/%h", bus.done, seen(), to_bcd(250));
      end
      shown = to_bcd(250);
      tick();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_abort();
      int n;
      bus.start = 1'b1;
      bus.value = 12'd3000;
      tick();                                  // edge k
      bus.start = 1'b0;
      for (int c = 1; c <= 6; c++) tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, seen()} !== 18'h0) begin
         failures++;
         $display("FAIL abort_immediate: busy=%b done=%b digits=%h, need 0/0/0000",
                  bus.busy, bus.done, seen());
      end
      for (int c = 0; c < 3; c++) tick();
      reset = 1'b1;
      shown = 16'h0000;
      for (int c = 0; c < 15; c++) begin
         tick();
         checks++;
         if ({bus.busy, bus.done, seen()} !== 18'h0) begin
            failures++;
            $display("FAIL abort_no_done cycle %0d: busy=%b done=%b digits=%h, need 0/0/0000",
                     c, bus.busy, bus.done, seen());
         end
      end
      bus.start = 1'b1;
      bus.value = 12'd5;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (!bus.done && n < 20) begin tick(); n++; end
      checks++;
      if (bus.done !== 1'b1 || seen() !== to_bcd(5)) begin
         failures++;
         $display("FAIL abort_recover: done=%b digits=%h, need 1/%h", bus.done, seen(), to_bcd(5));
      end
      shown = to_bcd(5);
      tick();
   endtask

   // ------------------------------------------------------------------------
   // Every 12-bit value once, in a random odd-stride order, with the operand
   // scrambled after acceptance and random idle gaps.
   task automatic test_sweep();
      int off;
      int v;
      int n;
      logic [15:0] got;
      off = int'($urandom_range(0, 4095));
      for (int i = 0; i < 4096; i++) begin
         v = (off + i * 2731) % 4096;
         bus.start = 1'b1;
         bus.value = 12'(v);
         tick();
         bus.start = 1'b0;
         bus.value = 12'($urandom);
         n = 0;
         while (!bus.done && n < 14) begin tick(); n++; end
         got = seen();
         checks++;
         if (bus.done !== 1'b1 || n != 12 || got !== to_bcd(v)) begin
            failures++;
            $display("FAIL sweep v=%0d: done=%b after %0d cycles digits=%h, need 1 after 12 cycles %h",
                     v, bus.done, n, got, to_bcd(v));
         end
         checks++;
         if (got[15:12] > 4'd9 || got[11:8] > 4'd9 || got[7:4] > 4'd9 || got[3:0] > 4'd9) begin
            failures++;
            $display("FAIL sweep_range v=%0d: digits=%h, need each <= 9", v, got);
         end
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.value = '0;
      test_reset();
      test_latency();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      test_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
